// File: rtl/dct_pkg.sv
// Shared constants for the forward 8-point DCT column stage.
// Holds the control encodings and the Q12 half-table of cosine coefficients.
package dct_pkg;

   localparam logic [1:0] CTRL_IDLE = 2'b00;
   localparam logic [1:0] CTRL_VLD  = 2'b01;
   localparam logic [1:0] CTRL_SOR  = 2'b11;

   localparam int FRAC      = 12;
   localparam int COEF_BITS = 14;

   // C[k][n] for n=0..3; the other half follows from (-1)^k symmetry via the butterfly
   localparam logic signed [COEF_BITS-1:0] COEF [8][4] = '{
      '{ 14'sd1448,  14'sd1448,  14'sd1448,  14'sd1448},
      '{ 14'sd2009,  14'sd1703,  14'sd1138,  14'sd400 },
      '{ 14'sd1892,  14'sd784,  -14'sd784,  -14'sd1892},
      '{ 14'sd1703, -14'sd400,  -14'sd2009, -14'sd1138},
      '{ 14'sd1448, -14'sd1448, -14'sd1448,  14'sd1448},
      '{ 14'sd1138, -14'sd2009,  14'sd400,   14'sd1703},
      '{ 14'sd784,  -14'sd1892,  14'sd1892, -14'sd784 },
      '{ 14'sd400,  -14'sd1138,  14'sd1703, -14'sd2009}
   };

   function automatic logic signed [COEF_BITS-1:0] coef_at(input logic [2:0] k,
                                                           input logic [1:0] n);
      return COEF[k][n];
   endfunction

endpackage

// File: rtl/dct8_mac4.sv
// Four-tap multiply-accumulate for one DCT coefficient per cycle.
// Rounds the Q12 sum to nearest, saturates to WIDTH_Y and registers the result.
module dct8_mac4
   import dct_pkg::*;
#(
   parameter int WIDTH_D = 17,
   parameter int WIDTH_Y = 16,
   parameter int COEF_W  = 14
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      en,
   input  logic [2:0]                k,
   input  logic signed [WIDTH_D-1:0] opd [4],
   output logic [1:0]                ctrl_out,
   output logic signed [WIDTH_Y-1:0] y_out
);

   localparam int ACC_W = WIDTH_D + COEF_W + 2;
   localparam logic signed [ACC_W-1:0] HALF  =
      {{(ACC_W-FRAC){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};
   localparam logic signed [ACC_W-1:0] Y_MAX =
      {{(ACC_W-WIDTH_Y+1){1'b0}}, {(WIDTH_Y-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] Y_MIN =
      {{(ACC_W-WIDTH_Y+1){1'b1}}, {(WIDTH_Y-1){1'b0}}};

   logic signed [COEF_W-1:0]  coef_s [4];
   logic signed [ACC_W-1:0]   acc_s;
   logic signed [ACC_W-1:0]   rnd_s;
   logic signed [ACC_W-1:0]   shr_s;
   logic signed [WIDTH_Y-1:0] y_s;
   logic [1:0]                ctrl_r;
   logic signed [WIDTH_Y-1:0] y_r;

   function automatic logic signed [WIDTH_Y-1:0] sat_y(input logic signed [ACC_W-1:0] v);
      if (v > Y_MAX) begin
         return {1'b0, {(WIDTH_Y-1){1'b1}}};
      end else if (v < Y_MIN) begin
         return {1'b1, {(WIDTH_Y-1){1'b0}}};
      end else begin
         return v[WIDTH_Y-1:0];
      end
   endfunction

   // dot product of the four butterfly operands with row k of the table, then round
   always_comb begin
      acc_s = '0;
      for (int i = 0; i < 4; i++) begin
         coef_s[i] = COEF_W'(coef_at(k, 2'(i)));
         acc_s     = acc_s + ACC_W'(opd[i]) * ACC_W'(coef_s[i]);
      end
      rnd_s = acc_s + HALF;
      shr_s = rnd_s >>> FRAC;
      y_s   = sat_y(shr_s);
   end

   // output register: y holds its last value while idle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ctrl_r <= CTRL_IDLE;
         y_r    <= '0;
      end else if (en) begin
         ctrl_r <= (k == 3'd0) ? CTRL_SOR : CTRL_VLD;
         y_r    <= y_s;
      end else begin
         ctrl_r <= CTRL_IDLE;
      end
   end

   assign ctrl_out = ctrl_r;
   assign y_out    = y_r;

endmodule

// File: rtl/dct_col.sv
// Forward 8-point 1-D DCT column stage: serial samples in, serial coefficients out.
// Row buffer -> shadow buffer -> butterfly register -> 8-cycle MAC sequencer.
module dct_col
   import dct_pkg::*;
#(
   parameter int WIDTH_X = 16,
   parameter int WIDTH_Y = 16,
   parameter int COEF_W  = 14
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [1:0]                ctrl_in,
   input  logic signed [WIDTH_X-1:0] x_in,
   output logic [1:0]                ctrl_out,
   output logic signed [WIDTH_Y-1:0] y_out,
   output logic                      err_out
);

   localparam int WIDTH_D = WIDTH_X + 1;

   logic                      vld_s;
   logic                      sor_s;
   logic                      complete_s;
   logic [2:0]                n_r;
   logic signed [WIDTH_X-1:0] row_r [7];
   logic signed [WIDTH_X-1:0] sh_r [8];
   logic                      sh_vld_r;
   logic signed [WIDTH_D-1:0] s_r [4];
   logic signed [WIDTH_D-1:0] d_r [4];
   logic                      bfly_vld_r;
   logic                      busy_r;
   logic [2:0]                k_r;
   logic                      mac_en_s;
   logic [2:0]                mac_k_s;
   logic signed [WIDTH_D-1:0] opd_s [4];
   logic                      err_r;

   assign vld_s      = ctrl_in[0];
   assign sor_s      = ctrl_in[0] & ctrl_in[1];
   assign complete_s = vld_s & ~sor_s & (n_r == 3'd7);
   assign mac_en_s   = bfly_vld_r | busy_r;
   assign mac_k_s    = bfly_vld_r ? 3'd0 : k_r;

   // input side: sample counter, row buffer and restart error flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         n_r   <= 3'd0;
         err_r <= 1'b0;
         for (int i = 0; i < 7; i++) begin
            row_r[i] <= '0;
         end
      end else begin
         err_r <= sor_s & (n_r != 3'd0);
         if (sor_s) begin
            row_r[0] <= x_in;
            n_r      <= 3'd1;
         end else if (vld_s && (n_r != 3'd0)) begin
            for (int i = 1; i < 7; i++) begin
               if (n_r == 3'(i)) begin
                  row_r[i] <= x_in;
               end
            end
            n_r <= n_r + 3'd1;
         end
      end
   end

   // shadow copy of a finished row; x[7] is taken straight from the input
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sh_vld_r <= 1'b0;
         for (int i = 0; i < 8; i++) begin
            sh_r[i] <= '0;
         end
      end else begin
         sh_vld_r <= complete_s;
         if (complete_s) begin
            for (int i = 0; i < 7; i++) begin
               sh_r[i] <= row_r[i];
            end
            sh_r[7] <= x_in;
         end
      end
   end

   // butterfly register; stays stable for the eight MAC cycles of its row
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bfly_vld_r <= 1'b0;
         for (int i = 0; i < 4; i++) begin
            s_r[i] <= '0;
            d_r[i] <= '0;
         end
      end else begin
         bfly_vld_r <= sh_vld_r;
         if (sh_vld_r) begin
            for (int i = 0; i < 4; i++) begin
               s_r[i] <= WIDTH_D'(sh_r[i]) + WIDTH_D'(sh_r[7-i]);
               d_r[i] <= WIDTH_D'(sh_r[i]) - WIDTH_D'(sh_r[7-i]);
            end
         end
      end
   end

   // output sequencer: k=0 issues on the start cycle, k=1..7 follow back to back
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_r <= 1'b0;
         k_r    <= 3'd0;
      end else if (bfly_vld_r) begin
         busy_r <= 1'b1;
         k_r    <= 3'd1;
      end else if (busy_r) begin
         busy_r <= (k_r != 3'd7);
         k_r    <= k_r + 3'd1;
      end
   end

   // even k use the sums, odd k the differences
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         opd_s[i] = mac_k_s[0] ? d_r[i] : s_r[i];
      end
   end

   dct8_mac4 #(
      .WIDTH_D (WIDTH_D),
      .WIDTH_Y (WIDTH_Y),
      .COEF_W  (COEF_W)
   ) u_mac (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (mac_en_s),
      .k        (mac_k_s),
      .opd      (opd_s),
      .ctrl_out (ctrl_out),
      .y_out    (y_out)
   );

   assign err_out = err_r;

endmodule

// File: tb/tb_dct_col.sv
// Randomized bench for dct_col against a direct 8x8 DCT reference model.
// The model tracks accepted samples and schedules every expected output cycle.
module tb_dct_col;

   localparam real PI = 3.14159265358979323846;

   typedef logic signed [15:0] row_t [8];
   typedef struct {
      int               cyc;
      logic [1:0]       ctrl;
      logic signed [15:0] y;
   } exp_t;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic [1:0]         ctrl_in = 2'b00;
   logic signed [15:0] x_in = 16'sd0;
   logic [1:0]         ctrl_out;
   logic signed [15:0] y_out;
   logic               err_out;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int cf [8][8];
   exp_t exp_q [$];
   int err_q [$];
   row_t m_x;
   int m_n = 0;
   logic signed [15:0] last_y = 16'sd0;
   logic [1:0] cmp_ec;
   logic signed [15:0] cmp_ey;
   logic cmp_ee;
   row_t pin_row;

   dct_col #(.WIDTH_X(16), .WIDTH_Y(16), .COEF_W(14)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .ctrl_in  (ctrl_in),
      .x_in     (x_in),
      .ctrl_out (ctrl_out),
      .y_out    (y_out),
      .err_out  (err_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
      end
   endtask

   function automatic void build_coefs();
      for (int k = 0; k < 8; k++) begin
         for (int n = 0; n < 8; n++) begin
            real ck;
            real v;
            ck = (k == 0) ? 1.0 / $sqrt(2.0) : 1.0;
            v  = 4096.0 * ck / 2.0 * $cos(real'((2 * n + 1) * k) * PI / 16.0);
            cf[k][n] = (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
         end
      end
   endfunction

   function automatic logic signed [15:0] ref_y(input row_t xs, input int k);
      longint acc;
      acc = 0;
      for (int n = 0; n < 8; n++) begin
         acc += longint'(cf[k][n]) * longint'(xs[n]);
      end
      acc = (acc + 2048) >>> 12;
      if (acc > 32767) acc = 32767;
      if (acc < -32768) acc = -32768;
      return 16'(acc);
   endfunction

   // reference model: tracks accepted samples and schedules outputs
   initial forever begin
      @(posedge clk);
      cyc++;
      if (!rst_n) begin
         m_n = 0;
         exp_q.delete();
         err_q.delete();
         last_y = 16'sd0;
      end else if (ctrl_in[0]) begin
         if (ctrl_in[1]) begin
            if (m_n != 0) err_q.push_back(cyc);
            m_x[0] = x_in;
            m_n = 1;
         end else if (m_n != 0) begin
            m_x[m_n] = x_in;
            if (m_n == 7) begin
               for (int k = 0; k < 8; k++) begin
                  exp_q.push_back('{cyc + 2 + k, (k == 0) ? 2'b11 : 2'b01, ref_y(m_x, k)});
               end
               m_n = 0;
            end else begin
               m_n++;
            end
         end
      end
   end

   // compare process: every cycle out of reset
   initial forever begin
      @(negedge clk);
      if (rst_n) begin
         cmp_ec = 2'b00;
         cmp_ey = last_y;
         cmp_ee = 1'b0;
         if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            cmp_ec = exp_q[0].ctrl;
            cmp_ey = exp_q[0].y;
            last_y = cmp_ey;
            void'(exp_q.pop_front());
         end
         if (err_q.size() > 0 && err_q[0] == cyc) begin
            cmp_ee = 1'b1;
            void'(err_q.pop_front());
         end
         check("ctrl_out", ctrl_out, cmp_ec);
         check("y_out", y_out, cmp_ey);
         check("err_out", err_out, cmp_ee);
      end
   end

   task automatic drive(input logic [1:0] c, input logic signed [15:0] v);
      @(negedge clk);
      ctrl_in = c;
      x_in    = v;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         drive({1'($urandom_range(0, 1)), 1'b0}, 16'($urandom));
      end
   endtask

   task automatic send_row(input row_t r, input int gap_pct);
      for (int i = 0; i < 8; i++) begin
         if (i != 0 && gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
            idle($urandom_range(1, 3));
         end
         drive((i == 0) ? 2'b11 : 2'b01, r[i]);
      end
   endtask

   function automatic row_t rand_row();
      row_t r;
      for (int i = 0; i < 8; i++) r[i] = 16'($urandom);
      return r;
   endfunction

   function automatic row_t const_row(input logic signed [15:0] v);
      row_t r;
      for (int i = 0; i < 8; i++) r[i] = v;
      return r;
   endfunction

   initial begin
      build_coefs();

      // pin the model with hand-computed values
      check("model_c00", cf[0][0], 1448);
      check("model_c10", cf[1][0], 2009);
      check("model_c73", cf[7][3], -2009);
      pin_row = const_row(16'sd100);
      check("model_dc_y0", ref_y(pin_row, 0), 283);
      check("model_dc_y1", ref_y(pin_row, 1), 0);
      check("model_dc_y4", ref_y(pin_row, 4), 0);
      pin_row = const_row(16'sd0);
      pin_row[0] = 16'sd64;
      check("model_imp_y0", ref_y(pin_row, 0), 23);
      check("model_imp_y1", ref_y(pin_row, 1), 31);
      pin_row = const_row(16'sd32767);
      check("model_sat_pos", ref_y(pin_row, 0), 32767);
      pin_row = const_row(-16'sd32768);
      check("model_sat_neg", ref_y(pin_row, 0), -32768);

      #12;
      check("reset_ctrl_out", ctrl_out, 0);
      check("reset_y_out", y_out, 0);
      check("reset_err_out", err_out, 0);
      @(negedge clk);
      #2 rst_n = 1'b1;

      // 01 before any sync is dropped
      for (int i = 0; i < 3; i++) drive(2'b01, 16'sd555);
      idle(2);

      send_row(const_row(16'sd100), 0);
      idle(12);
      pin_row = const_row(16'sd0);
      pin_row[0] = 16'sd64;
      send_row(pin_row, 0);
      idle(12);

      // back-to-back rows
      for (int r = 0; r < 16; r++) send_row(rand_row(), 0);
      idle(12);

      // restart at n=5: error pulse, partial row discarded
      drive(2'b11, 16'($urandom));
      for (int i = 0; i < 4; i++) drive(2'b01, 16'($urandom));
      send_row(rand_row(), 0);
      idle(12);

      // rows with idle gaps
      for (int r = 0; r < 6; r++) send_row(rand_row(), 30);
      idle(12);

      send_row(const_row(16'sd32767), 0);
      send_row(const_row(-16'sd32768), 0);
      idle(12);

      // reset while a row is streaming out
      send_row(rand_row(), 0);
      idle(5);
      #2 rst_n = 1'b0;
      #1;
      check("rst_mid_ctrl_out", ctrl_out, 0);
      check("rst_mid_y_out", y_out, 0);
      check("rst_mid_err_out", err_out, 0);
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b1;
      for (int i = 0; i < 6; i++) drive(2'b01, 16'($urandom));
      idle(3);
      send_row(rand_row(), 20);
      idle(14);

      check("exp_queue_drained", exp_q.size(), 0);
      check("err_queue_drained", err_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
